// File: rtl/sb_tx_fpga.sv
// sb_tx_fpga: pushes upstream packets into a memory-resident ring queue and publishes the producer head
module sb_tx_fpga #(
  parameter int DW            = 416,
  parameter int HEAD_OFFSET   = 0,
  parameter int TAIL_OFFSET   = 64,
  parameter int PACKET_OFFSET = 128,
  parameter int PACKET_SIZE   = 64
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic [DW-1:0] data,
  input  logic [31:0]   dest,
  input  logic          last,
  input  logic          valid,
  output logic          ready,
  input  logic [63:0]   cfg_base_addr,
  input  logic [31:0]   cfg_capacity,
  output logic          status_idle,
  output logic          status_fault,
  output logic [63:0]   fault_addr,
  output logic          mem_wvalid,
  output logic [63:0]   mem_waddr,
  output logic [63:0]   mem_wstrb,
  output logic [511:0]  mem_wdata,
  input  logic          mem_wready,
  output logic          mem_rvalid,
  output logic [63:0]   mem_raddr,
  input  logic [511:0]  mem_rdata,
  input  logic          mem_rready
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_TAIL   = 3'd1;
  localparam logic [2:0] WR_PACKET = 3'd2;
  localparam logic [2:0] WR_HEAD   = 3'd3;
  localparam logic [2:0] FAULT     = 3'd4;
  localparam int STRB_BYTES = 8 + DW / 8;
  localparam logic [63:0] PKT_STRB = STRB_BYTES >= 64 ? '1 : (64'd1 << STRB_BYTES) - 64'd1;

  logic [2:0]   state, state_nxt;
  logic [31:0]  head, tail, head_incr;
  logic         full, full_rd, wr_req, legal, fault_hit;
  logic [63:0]  waddr, limit;
  logic [63:0]  wstrb;
  logic [511:0] wdata;
  logic         unused_rdata;

  assign unused_rdata = ^mem_rdata[511:32];

  // Queue arithmetic, candidate write request and its bounds check against the queue window
  always_comb begin
    head_incr = (head + 32'd1 == cfg_capacity) ? 32'd0 : head + 32'd1;
    full      = head_incr == tail;
    full_rd   = head_incr == mem_rdata[31:0];
    wr_req    = state == WR_PACKET || state == WR_HEAD;
    waddr     = state == WR_PACKET ? cfg_base_addr + 64'(PACKET_OFFSET) + 64'(head) * 64'(PACKET_SIZE)
                                   : cfg_base_addr + 64'(HEAD_OFFSET);
    wdata     = state == WR_PACKET ? (512'(data) << 64) | {479'b0, last, dest} : {480'b0, head};
    wstrb     = state == WR_PACKET ? PKT_STRB : 64'hff;
    limit     = cfg_base_addr + 64'(cfg_capacity) * 64'(PACKET_SIZE) + 64'(PACKET_OFFSET);
    legal     = waddr >= cfg_base_addr && waddr < limit;
    fault_hit = wr_req && !legal;
  end

  // Memory-side outputs are zero whenever no request is being made; illegal writes never leave the block
  always_comb begin
    mem_wvalid  = wr_req && legal;
    mem_waddr   = mem_wvalid ? waddr : 64'd0;
    mem_wdata   = mem_wvalid ? wdata : 512'd0;
    mem_wstrb   = mem_wvalid ? wstrb : 64'd0;
    mem_rvalid  = state == RD_TAIL;
    mem_raddr   = mem_rvalid ? cfg_base_addr + 64'(TAIL_OFFSET) : 64'd0;
    ready       = state == WR_PACKET && mem_wready && legal;
    status_idle = state == IDLE;
  end

  // Next state; a tail read decides on the freshly returned tail value rather than the stale register
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = (en && valid) ? (full ? RD_TAIL : WR_PACKET) : IDLE;
      RD_TAIL:   state_nxt = !mem_rready ? RD_TAIL : !full_rd ? WR_PACKET : en ? RD_TAIL : IDLE;
      WR_PACKET: state_nxt = fault_hit ? FAULT : mem_wready ? WR_HEAD : WR_PACKET;
      WR_HEAD:   state_nxt = fault_hit ? FAULT : mem_wready ? IDLE : WR_HEAD;
      FAULT:     state_nxt = FAULT;
      default:   state_nxt = IDLE;
    endcase
  end

  // State, queue pointers and the sticky fault record
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      head         <= 32'd0;
      tail         <= 32'd0;
      status_fault <= 1'b0;
      fault_addr   <= 64'd0;
    end else begin
      state <= state_nxt;
      if (state == RD_TAIL && mem_rready) tail <= mem_rdata[31:0];
      if (ready) head <= head_incr;
      if (fault_hit) begin
        status_fault <= 1'b1;
        fault_addr   <= waddr;
      end
    end
  end
endmodule

// File: doc/sb_tx_fpga.md
SB_TX_FPGA -- requirements
Module: sb_tx_fpga

Interface
REQ-001 Parameter DW, default 416, packet payload width in bits; SHALL be <= 448.
REQ-002 Parameter HEAD_OFFSET, default 0, byte offset of the producer head word from cfg_base_addr.
REQ-003 Parameter TAIL_OFFSET, default 64, byte offset of the consumer tail word.
REQ-004 Parameter PACKET_OFFSET, default 128, byte offset of packet slot 0.
REQ-005 Parameter PACKET_SIZE, default 64, byte stride between packet slots.
REQ-006 Ports SHALL be as follows; one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock
- nreset  in  1  async active-low reset
- en  in  1  enable new transactions
- data  in  DW  packet payload
- dest  in  32  packet destination
- last  in  1  packet last flag
- valid  in  1  upstream packet valid
- ready  out  1  packet accepted this cycle
- cfg_base_addr  in  64  queue base byte address
- cfg_capacity  in  32  queue slot count
- status_idle  out  1  FSM in IDLE
- status_fault  out  1  sticky out-of-bounds fault
- fault_addr  out  64  first faulting write address
- mem_wvalid  out  1  write request
- mem_waddr  out  64  write byte address
- mem_wstrb  out  64  write byte enables
- mem_wdata  out  512  write data
- mem_wready  in  1  one-cycle write-complete pulse
- mem_rvalid  out  1  read request
- mem_raddr  out  64  read byte address
- mem_rdata  in  512  read data, valid with mem_rready
- mem_rready  in  1  one-cycle read-complete pulse

Function
REQ-007 States: IDLE, RD_TAIL, WR_PACKET, WR_HEAD, FAULT.
REQ-008 head_incr = 0 if head+1 == cfg_capacity, else head+1 (32-bit); full = (head_incr == tail); capacity N holds at most N-1 packets.
REQ-009 IDLE: if en && valid, go to WR_PACKET when !full, else RD_TAIL; otherwise stay.
REQ-010 RD_TAIL: mem_rvalid=1, mem_raddr=cfg_base_addr+TAIL_OFFSET; on mem_rready, tail <= mem_rdata[31:0]; next state evaluated on the updated tail: !full -> WR_PACKET; full && !en -> IDLE; full && en -> remain (new read issued).
REQ-011 WR_PACKET: mem_wvalid=1, mem_waddr=cfg_base_addr+PACKET_OFFSET+head*PACKET_SIZE, mem_wdata={zeros, data at [DW+63:64], 31'b0, last at [32], dest at [31:0]}, mem_wstrb = low (8+DW/8) bits set.
REQ-012 ready = (state==WR_PACKET) && mem_wready && !fault condition (combinational); at that edge head <= head_incr, next state WR_HEAD; WR_PACKET is not abandoned on !en.
REQ-013 WR_HEAD: mem_wvalid=1, mem_waddr=cfg_base_addr+HEAD_OFFSET, mem_wdata={480'b0, head}, mem_wstrb=64'hff; on mem_wready -> IDLE.
REQ-014 mem_rvalid/mem_wvalid SHALL stay high with stable address/data/strobe until the matching ready pulse; all mem outputs are 0 when not requesting.
REQ-015 Upstream SHALL hold valid/data/dest/last stable until ready; block never asserts ready without valid high.
REQ-016 Write bounds check: legal iff cfg_base_addr <= mem_waddr < cfg_base_addr + cfg_capacity*PACKET_SIZE + PACKET_OFFSET (64-bit arithmetic).
REQ-017 Illegal write: mem_wvalid gated to 0 that cycle, ready 0, status_fault set and fault_addr captured at next edge, state -> FAULT.
REQ-018 FAULT is terminal; only nreset exits; status_idle=0 in FAULT.
REQ-019 Only one of mem_rvalid/mem_wvalid SHALL be high in any cycle.

Reset
REQ-020 nreset low SHALL immediately (no clock edge) force state=IDLE, head=0, tail=0, status_fault=0, fault_addr=0; all mem request outputs and ready go 0.
REQ-021 Reset mid-transaction abandons the request; no memory-side cleanup is performed.

Verification
REQ-022 base 0x1000, cap 4, tail word 0: send dest=5,last=1,data=0xABC -> write 0x1080, wdata[31:0]=5, bit32=1, [479:64]=0xABC, wstrb=0x0FFF_FFFF_FFFF_FFFF; then write 0x1000 data 1 wstrb 0xff; status_idle returns.
REQ-023 Fill cap 4: three packets at 0x1080/0x10C0/0x1100; fourth causes repeated reads of 0x1040; return tail=2 -> packet at 0x1140, head write value 0 (wrap).
REQ-024 Queue full, en dropped during RD_TAIL, tail read returns 0 -> IDLE after read, no write, ready never asserted.
REQ-025 cap 0 (legal length 128): packet write to 0x1080 -> mem_wvalid never high, status_fault=1, fault_addr=0x1080, ignored until nreset.
REQ-026 mem_wready held low 10 cycles in WR_PACKET -> ready low, mem_waddr/mem_wdata stable throughout; accepted on first wready.
REQ-027 nreset asserted mid WR_HEAD between clock edges -> mem_wvalid drops immediately; after release, next packet writes slot 0 at 0x1080.
